mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter_pkg.sv | 10 +
 rtl/mem_req_arbiter_if.sv | 37 +++
 rtl/mem_req_arbiter_rr_pick.sv | 20 ++
 rtl/mem_req_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_req_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// gba_io_pkg: shared FSM states and access-width codes for the memory request arbiter
package gba_io_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
  localparam logic [1:0] W8 = 2'b01;
  localparam logic [1:0] W16 = 2'b10;
  localparam logic [1:0] W32 = 2'b11;
  function automatic logic [1:0] norm_width(input logic [1:0] w);
    return (w == 2'b00) ? W32 : w;
  endfunction
endpackage

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: requester channels plus the single shared memory command port
interface mem_req_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0] ch_rd;
  logic [NUM_CH-1:0] ch_wr;
  logic [NUM_CH-1:0][1:0] ch_width;
  logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] ch_wr_data;
  logic [NUM_CH-1:0] ch_ack;
  logic [NUM_CH-1:0] ch_err;
  logic [NUM_CH-1:0] ch_rd_valid;
  logic [DATA_W-1:0] ch_rd_data;
  logic mem_rd;
  logic mem_wr;
  logic mem_rd_ready;
  logic mem_wr_ready;
  logic mem_rd_valid;
  logic [1:0] mem_data_width;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;
  modport slave (
    input ch_rd, ch_wr, ch_width, ch_addr, ch_wr_data,
    input mem_rd_ready, mem_wr_ready, mem_rd_valid, mem_rd_data,
    output ch_ack, ch_err, ch_rd_valid, ch_rd_data,
    output mem_rd, mem_wr, mem_data_width, mem_addr, mem_wr_data
  );
  modport master (
    output ch_rd, ch_wr, ch_width, ch_addr, ch_wr_data,
    output mem_rd_ready, mem_wr_ready, mem_rd_valid, mem_rd_data,
    input ch_ack, ch_err, ch_rd_valid, ch_rd_data,
    input mem_rd, mem_wr, mem_data_width, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/mem_req_arbiter_rr_pick.sv
// rr_pick: one-hot grant of the first pending requester at or after the base index
module rr_pick #(
  parameter int NUM_CH = 2,
  parameter int PTR_W = 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  input  logic              i_rr,
  output logic [NUM_CH-1:0] o_gnt
);
  logic [PTR_W-1:0] w_base;
  assign w_base = i_rr ? i_ptr : '0;
  // scan offsets farthest-first so the nearest pending requester from the base is the last write
  always_comb begin
    o_gnt = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      for (int i = 0; i < NUM_CH; i++)
        if (i_req[i] && i == (int'(w_base) + k) % NUM_CH) o_gnt = NUM_CH'(1) << i;
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: grants one requester channel at a time onto a single memory port with timeout
module mem_req_arbiter
  import gba_io_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input logic clk,
  input logic rst,
  mem_req_arbiter_if.slave bus
);
  localparam int PTR_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  state_t r_state, w_state_nxt;
  logic [NUM_CH-1:0] w_req, w_gnt, r_gnt, r_ack, r_err, r_rd_valid;
  logic [PTR_W-1:0] w_idx, r_idx, r_ptr, w_nxt_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_rd_data, w_rd_ext, r_wr_data;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0] r_width;
  logic r_is_rd, r_mem_rd, r_mem_wr, w_rd_sel;
  logic w_start, w_to_wait, w_done_wr, w_done_rd, w_tmo, w_cnt_hit;
  assign w_req = bus.ch_rd | bus.ch_wr;
  assign w_rd_sel = |(bus.ch_rd & w_gnt);
  assign w_nxt_ptr = (r_idx == PTR_W'(NUM_CH - 1)) ? '0 : r_idx + 1'b1;
  assign w_cnt_hit = r_cnt >= CNT_W'(TIMEOUT_CYC - 1);
  assign w_rd_ext = (r_width == W8) ? DATA_W'(bus.mem_rd_data[7:0]) :
                    (r_width == W16) ? DATA_W'(bus.mem_rd_data[15:0]) : bus.mem_rd_data;
  rr_pick #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_pick (
    .i_req(w_req),
    .i_ptr(r_ptr),
    .i_rr (1'(RR_MODE)),
    .o_gnt(w_gnt)
  );
  // binary index of the one-hot grant, used to select the winner's fields
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_CH; i++) if (w_gnt[i]) w_idx = PTR_W'(i);
  end
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_state_nxt;
  // next state and transaction events; completion takes precedence over timeout
  always_comb begin
    w_state_nxt = r_state;
    w_start = 1'b0;
    w_to_wait = 1'b0;
    w_done_wr = 1'b0;
    w_done_rd = 1'b0;
    w_tmo = 1'b0;
    case (r_state)
      IDLE: if (|w_req) begin
        w_start = 1'b1;
        w_state_nxt = ISSUE;
      end
      ISSUE: if (r_is_rd ? bus.mem_rd_ready : bus.mem_wr_ready) begin
        w_to_wait = r_is_rd;
        w_done_wr = !r_is_rd;
        w_state_nxt = r_is_rd ? WAIT_RD : IDLE;
      end else if (w_cnt_hit) begin
        w_tmo = 1'b1;
        w_state_nxt = IDLE;
      end
      WAIT_RD: if (bus.mem_rd_valid) begin
        w_done_rd = 1'b1;
        w_state_nxt = IDLE;
      end else if (w_cnt_hit) begin
        w_tmo = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // latch the winner, drive the memory command and raise the per-channel result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt <= '0;
      r_idx <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
      r_is_rd <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_addr <= '0;
      r_width <= '0;
      r_wr_data <= '0;
      r_rd_data <= '0;
      r_ack <= '0;
      r_err <= '0;
      r_rd_valid <= '0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      r_rd_valid <= '0;
      r_cnt <= (r_state == IDLE) ? '0 : r_cnt + 1'b1;
      if (w_start) begin
        r_gnt <= w_gnt;
        r_idx <= w_idx;
        r_is_rd <= w_rd_sel;
        r_mem_rd <= w_rd_sel;
        r_mem_wr <= !w_rd_sel;
        r_addr <= bus.ch_addr[w_idx];
        r_width <= norm_width(bus.ch_width[w_idx]);
        r_wr_data <= bus.ch_wr_data[w_idx];
      end
      if (w_to_wait || w_done_wr || w_tmo) begin
        r_mem_rd <= 1'b0;
        r_mem_wr <= 1'b0;
      end
      if (w_done_wr || w_done_rd) r_ack <= r_gnt;
      if (w_done_rd) begin
        r_rd_valid <= r_gnt;
        r_rd_data <= w_rd_ext;
      end
      if (w_tmo) r_err <= r_gnt;
      if (w_done_wr || w_done_rd || w_tmo) r_ptr <= w_nxt_ptr;
    end
  end
  assign bus.ch_ack = r_ack;
  assign bus.ch_err = r_err;
  assign bus.ch_rd_valid = r_rd_valid;
  assign bus.ch_rd_data = r_rd_data;
  assign bus.mem_rd = r_mem_rd;
  assign bus.mem_wr = r_mem_wr;
  assign bus.mem_data_width = r_width;
  assign bus.mem_addr = r_addr;
  assign bus.mem_wr_data = r_wr_data;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: scoreboard bench for round-robin and fixed-priority arbiter instances
module tb_mem_req_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [1:0] ack;
    logic [1:0] err;
    logic [1:0] rv;
    logic [31:0] data;
    int cyc;
  } resp_t;
  typedef struct {
    logic rd;
    logic wr;
    logic [25:0] addr;
    logic [1:0] width;
    logic [31:0] wdata;
    int cyc;
    int len;
  } cmd_t;
  resp_t q_m[$];
  resp_t q_f[$];
  cmd_t q_c[$];
  logic c_prev = 1'b0;
  int c_rise = 0;
  int c_len = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mem_req_arbiter_if #(.NUM_CH(2), .ADDR_W(26), .DATA_W(32)) bus ();
  mem_req_arbiter_if #(.NUM_CH(2), .ADDR_W(26), .DATA_W(32)) bus_f ();
  mem_req_arbiter #(.NUM_CH(2), .ADDR_W(26), .DATA_W(32), .RR_MODE(1), .TIMEOUT_CYC(8)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  mem_req_arbiter #(.NUM_CH(2), .ADDR_W(26), .DATA_W(32), .RR_MODE(0), .TIMEOUT_CYC(8)) u_fx (
    .clk(clk),
    .rst(rst),
    .bus(bus_f.slave)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_ch(input int ch, input logic rd, input logic wr, input logic [1:0] w,
                        input logic [25:0] a, input logic [31:0] d);
    bus.ch_rd[ch] = rd;
    bus.ch_wr[ch] = wr;
    bus.ch_width[ch] = w;
    bus.ch_addr[ch] = a;
    bus.ch_wr_data[ch] = d;
    bus_f.ch_rd[ch] = rd;
    bus_f.ch_wr[ch] = wr;
    bus_f.ch_width[ch] = w;
    bus_f.ch_addr[ch] = a;
    bus_f.ch_wr_data[ch] = d;
  endtask
  task automatic mem(input logic rr, input logic wr, input logic vld, input logic [31:0] d);
    bus.mem_rd_ready = rr;
    bus.mem_wr_ready = wr;
    bus.mem_rd_valid = vld;
    bus.mem_rd_data = d;
    bus_f.mem_rd_ready = rr;
    bus_f.mem_wr_ready = wr;
    bus_f.mem_rd_valid = vld;
    bus_f.mem_rd_data = d;
  endtask
  task automatic exp_resp(input logic [1:0] ack, input logic [1:0] err, input logic [1:0] rv,
                          input logic [31:0] d, input int dc, input int which);
    resp_t e;
    e.ack = ack;
    e.err = err;
    e.rv = rv;
    e.data = d;
    e.cyc = cyc + dc;
    if (which[0]) q_m.push_back(e);
    if (which[1]) q_f.push_back(e);
  endtask
  task automatic exp_cmd(input logic rd, input logic wr, input logic [25:0] a, input logic [1:0] w,
                         input logic [31:0] d, input int dc, input int len);
    cmd_t e;
    e.rd = rd;
    e.wr = wr;
    e.addr = a;
    e.width = w;
    e.wdata = d;
    e.cyc = cyc + dc;
    e.len = len;
    q_c.push_back(e);
  endtask
  task automatic wait_done(input int ch);
    int n = 0;
    while (!(bus.ch_ack[ch] || bus.ch_err[ch]) && n < 30) begin
      step();
      n++;
    end
    chk("done_within_bound", 32'(n < 30), 32'd1);
    set_ch(ch, 1'b0, 1'b0, 2'b00, '0, '0);
  endtask
  task automatic zero_chk(input string tag);
    chk({tag, "_ack"}, 32'(bus.ch_ack), 0);
    chk({tag, "_err"}, 32'(bus.ch_err), 0);
    chk({tag, "_rv"}, 32'(bus.ch_rd_valid), 0);
    chk({tag, "_rd_data"}, bus.ch_rd_data, 0);
    chk({tag, "_mem_cmd"}, 32'({bus.mem_rd, bus.mem_wr}), 0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_mem_width"}, 32'(bus.mem_data_width), 0);
    chk({tag, "_mem_wdata"}, bus.mem_wr_data, 0);
    chk({tag, "_fx_ack"}, 32'(bus_f.ch_ack), 0);
  endtask
  task automatic cmp_resp(input string tag, input logic have, input resp_t e,
                          input logic [1:0] ack, input logic [1:0] err, input logic [1:0] rv,
                          input logic [31:0] d);
    if (!have) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected got ack=%b err=%b rv=%b exp=none (cycle %0d)", tag, ack, err, rv, cyc);
    end else begin
      chk({tag, "_ack"}, 32'(ack), 32'(e.ack));
      chk({tag, "_err"}, 32'(err), 32'(e.err));
      chk({tag, "_rv"}, 32'(rv), 32'(e.rv));
      chk({tag, "_cycle"}, cyc, e.cyc);
      if (e.rv != 0) chk({tag, "_data"}, d, e.data);
    end
  endtask
  // response monitor for the round-robin instance
  always @(negedge clk) begin
    resp_t e;
    logic h;
    if (|bus.ch_ack || |bus.ch_err || |bus.ch_rd_valid) begin
      h = q_m.size() > 0;
      e = '{default: 0};
      if (h) e = q_m.pop_front();
      cmp_resp("rr_resp", h, e, bus.ch_ack, bus.ch_err, bus.ch_rd_valid, bus.ch_rd_data);
    end
  end
  // response monitor for the fixed-priority instance
  always @(negedge clk) begin
    resp_t e;
    logic h;
    if (|bus_f.ch_ack || |bus_f.ch_err || |bus_f.ch_rd_valid) begin
      h = q_f.size() > 0;
      e = '{default: 0};
      if (h) e = q_f.pop_front();
      cmp_resp("fx_resp", h, e, bus_f.ch_ack, bus_f.ch_err, bus_f.ch_rd_valid, bus_f.ch_rd_data);
    end
  end
  // memory command monitor: fields checked on the rising cycle, duration on the falling one
  always @(negedge clk) begin
    logic now;
    cmd_t e;
    now = bus.mem_rd | bus.mem_wr;
    if (now && !c_prev) begin
      if (q_c.size() == 0) begin
        checks++;
        failures++;
        c_len = 0;
        $display("FAIL cmd_unexpected got rd=%b wr=%b addr=%h exp=none (cycle %0d)", bus.mem_rd, bus.mem_wr, bus.mem_addr, cyc);
      end else begin
        e = q_c.pop_front();
        chk("cmd_rd", 32'(bus.mem_rd), 32'(e.rd));
        chk("cmd_wr", 32'(bus.mem_wr), 32'(e.wr));
        chk("cmd_addr", 32'(bus.mem_addr), 32'(e.addr));
        chk("cmd_width", 32'(bus.mem_data_width), 32'(e.width));
        chk("cmd_wdata", bus.mem_wr_data, e.wdata);
        chk("cmd_cycle", cyc, e.cyc);
        c_len = e.len;
      end
      c_rise = cyc;
    end
    if (!now && c_prev && c_len != 0) chk("cmd_len", cyc - c_rise, c_len);
    c_prev = now;
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    set_ch(0, 1'b0, 1'b0, 2'b00, '0, '0);
    set_ch(1, 1'b0, 1'b0, 2'b00, '0, '0);
    mem(1'b0, 1'b0, 1'b0, '0);
    step(2);
    zero_chk("reset");
    rst = 1'b0;
    step();
    mem(1'b0, 1'b1, 1'b0, '0);
    exp_cmd(1'b0, 1'b1, 26'h100, 2'b11, 32'hDEADBEEF, 1, 1);
    exp_resp(2'b01, 2'b00, 2'b00, '0, 2, 3);
    set_ch(0, 1'b0, 1'b1, 2'b11, 26'h100, 32'hDEADBEEF);
    wait_done(0);
    step(2);
    mem(1'b1, 1'b0, 1'b1, 32'hCAFEBEEF);
    exp_cmd(1'b1, 1'b0, 26'h0AA, 2'b10, '0, 1, 1);
    exp_resp(2'b01, 2'b00, 2'b01, 32'h0000BEEF, 3, 3);
    set_ch(0, 1'b1, 1'b0, 2'b10, 26'h0AA, '0);
    wait_done(0);
    step(2);
    exp_cmd(1'b1, 1'b0, 26'h0BB, 2'b11, '0, 1, 1);
    exp_resp(2'b01, 2'b00, 2'b01, 32'hCAFEBEEF, 3, 3);
    set_ch(0, 1'b1, 1'b0, 2'b11, 26'h0BB, '0);
    wait_done(0);
    step(2);
    mem(1'b1, 1'b0, 1'b1, 32'h123456AB);
    exp_cmd(1'b1, 1'b0, 26'h1CC, 2'b01, '0, 1, 1);
    exp_resp(2'b10, 2'b00, 2'b10, 32'h000000AB, 3, 3);
    set_ch(1, 1'b1, 1'b0, 2'b01, 26'h1CC, '0);
    wait_done(1);
    step(2);
    mem(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      exp_cmd(1'b0, 1'b1, i[0] ? 26'h300 : 26'h200, 2'b11, i[0] ? 32'h22222222 : 32'h11111111, 2 * i + 1, 1);
      exp_resp(i[0] ? 2'b10 : 2'b01, 2'b00, 2'b00, '0, 2 * i + 2, 1);
      exp_resp(2'b01, 2'b00, 2'b00, '0, 2 * i + 2, 2);
    end
    set_ch(0, 1'b0, 1'b1, 2'b11, 26'h200, 32'h11111111);
    set_ch(1, 1'b0, 1'b1, 2'b11, 26'h300, 32'h22222222);
    step(8);
    set_ch(0, 1'b0, 1'b0, 2'b00, '0, '0);
    set_ch(1, 1'b0, 1'b0, 2'b00, '0, '0);
    step(2);
    mem(1'b1, 1'b0, 1'b1, 32'hA5A5A5A5);
    exp_cmd(1'b1, 1'b0, 26'h044, 2'b11, 32'h55AA55AA, 1, 1);
    exp_resp(2'b01, 2'b00, 2'b01, 32'hA5A5A5A5, 3, 3);
    set_ch(0, 1'b1, 1'b1, 2'b00, 26'h044, 32'h55AA55AA);
    wait_done(0);
    step(2);
    mem(1'b0, 1'b1, 1'b0, '0);
    exp_cmd(1'b1, 1'b0, 26'h080, 2'b11, '0, 1, 8);
    exp_resp(2'b00, 2'b01, 2'b00, '0, 9, 3);
    set_ch(0, 1'b1, 1'b0, 2'b11, 26'h080, '0);
    wait_done(0);
    step(2);
    exp_cmd(1'b0, 1'b1, 26'h040, 2'b01, 32'h0BADF00D, 1, 1);
    exp_resp(2'b01, 2'b00, 2'b00, '0, 2, 3);
    set_ch(0, 1'b0, 1'b1, 2'b01, 26'h040, 32'h0BADF00D);
    wait_done(0);
    step(2);
    mem(1'b1, 1'b0, 1'b0, 32'h77777777);
    exp_cmd(1'b1, 1'b0, 26'h0F0, 2'b11, '0, 1, 1);
    set_ch(0, 1'b1, 1'b0, 2'b11, 26'h0F0, '0);
    step(2);
    rst = 1'b1;
    set_ch(0, 1'b0, 1'b0, 2'b00, '0, '0);
    step();
    zero_chk("midrst");
    rst = 1'b0;
    mem(1'b1, 1'b0, 1'b1, 32'h77777777);
    repeat (4) begin
      step();
      chk("midrst_no_rv", 32'(bus.ch_rd_valid | bus_f.ch_rd_valid), 0);
    end
    mem(1'b0, 1'b0, 1'b0, '0);
    step(5);
    chk("rr_queue_drained", q_m.size(), 0);
    chk("fx_queue_drained", q_f.size(), 0);
    chk("cmd_queue_drained", q_c.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
